// File: rtl/pretty_bird_crash_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pretty_bird_crash_ctrl : crash detection, score and start gating for the bird
// Rev 1.0
// ---------------------------------------------------------------------------
module pretty_bird_crash_ctrl #(
  parameter int          ROWS        = 8,
  parameter logic [10:0] TICK_MAX    = 11'd1791,
  parameter int          CRASH_TICKS = 4,
  parameter int          SCORE_W     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               KEY0,
  input  logic               groundOut,
  input  logic [ROWS-1:0]    birdRow,
  input  logic [ROWS-1:0]    pipeRow,
  input  logic               pipeClear,
  output logic               lossDetect,
  output logic               playing,
  output logic [SCORE_W-1:0] score
);

  localparam int                 CNT_W      = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;
  localparam logic [CNT_W-1:0]   CRASH_LOAD = CNT_W'(CRASH_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_CRASH = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic [10:0]      presc;
  logic             tick;
  logic             collide;
  logic             start_req;
  logic             armed;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] crash_cnt;

  assign tick      = (presc == TICK_MAX);
  assign collide   = (|(birdRow & pipeRow)) | groundOut;
  assign start_req = tick & armed & ~KEY0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    presc <= 11'd0;
    else if (tick) presc <= 11'd0;
    else           presc <= presc + 11'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req) state_nxt = S_PLAY;
      S_PLAY:  if (tick && collide) state_nxt = S_CRASH;
      S_CRASH: if (tick && crash_cnt == '0) state_nxt = S_OVER;
      S_OVER:  if (start_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lossDetect = (state == S_CRASH);
    playing    = (state == S_PLAY);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      crash_cnt <= '0;
    else if (state == S_PLAY && state_nxt == S_CRASH)
      crash_cnt <= CRASH_LOAD;
    else if (tick && state == S_CRASH && crash_cnt != '0)
      crash_cnt <= crash_cnt - CNT_W'(1);
  end

  // Clearing on every transition forces a fresh release before the next start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  armed <= 1'b0;
    else if (state_nxt != state) armed <= 1'b0;
    else if (tick && KEY0)       armed <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      score <= '0;
    else if (state == S_OVER && state_nxt == S_IDLE)
      score <= '0;
    else if (tick && state == S_PLAY && !collide && pipeClear && score != SCORE_MAX)
      score <= score + SCORE_W'(1);
  end

endmodule
`default_nettype wire
